vec_elem_sequencer: RTL and testbench
=====================================

Name: vec_elem_sequencer

Overview:
- Sits downstream of the ID-stage vector-length setup logic.
- Latches its vl / vtype / remaining-AVL outputs into architectural CSRs.
- On each accepted vector instruction, steps element indices 0..vl-1 toward the EX lane with a valid/ready handshake.
- Stalls ID while the instruction is in flight.

Parameters:
- VLEN, 64, vector register length in bits (element counts below derive from 64).
- OPW, 6, width of the opaque vector opcode passed through to EX.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- vcsr_wen  in  1  CSR write strobe from the setup logic
- new_vl  in  7  vl value to latch
- new_vtype  in  7  vtype: [6] valid, [5:3] SEW enc, [2:0] LMUL enc
- new_AVL  in  7  remaining AVL to latch
- issue_valid  in  1  vector instruction presented by ID
- issue_ready  out  1  sequencer accepts the instruction this cycle
- issue_op  in  OPW  opcode
- issue_vd, issue_vs1, issue_vs2  in  5 each  base register numbers
- elem_valid  out  1  element beat valid toward EX
- elem_ready  in  1  EX accepts the beat
- elem_op  out  OPW  latched opcode
- elem_idx  out  6  element index
- elem_vd, elem_vs1, elem_vs2  out  5 each  physical register for this element
- elem_byte_off  out  3  byte offset of the element within the 64-bit register
- elem_sew  out  3  latched SEW encoding
- elem_last  out  1  this beat is index vl-1
- seq_done  out  1  one-cycle pulse after the last beat completes
- stall_id  out  1  ID must hold
- csr_vl, csr_vtype, csr_avl  out  7 each  architectural CSR values

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - csr_vl, csr_vtype, csr_avl = 0.
  - All elem_* outputs, seq_done and stall_id = 0.
  - issue_ready = 1 after reset deasserts.
  - Reset mid-RUN abandons the instruction with no seq_done.
- CSR write:
  - In IDLE, vcsr_wen=1 loads csr_vl/csr_vtype/csr_avl on the next edge.
  - If issue_valid is high in the same cycle, the CSR write has priority: issue_ready=0 that cycle and the issue is accepted on a later cycle against the new CSRs.
  - vcsr_wen outside IDLE is ignored; ID is stalled, so this is a protocol error and the bench asserts it never happens.
- States:
  - IDLE: issue_ready = !vcsr_wen. On issue_valid&&issue_ready, latch op/vd/vs1/vs2/SEW and set idx=0.
    - If csr_vtype[6]==0 or csr_vl==0, go to DONE (no beats).
    - Otherwise go to RUN.
  - RUN: elem_valid=1, stall_id=1, issue_ready=0.
    - On elem_valid&&elem_ready: idx increments.
    - If elem_last, go to DONE.
    - If elem_ready=0, all elem_* hold stable.
  - DONE: seq_done=1, stall_id=1, issue_ready=0 for exactly one cycle, then IDLE.
- Latency:
  - Issue accepted at edge T gives first elem_valid in cycle T+1.
  - One beat per cycle under continuous ready.
  - Back-to-back instructions are separated by one DONE cycle.
- Element mapping (SEW enc s in 0..3; elements per register = 8>>s):
  - reg_off = idx >> (3-s).
  - elem_byte_off = (idx & ((8>>s)-1)) << s, truncated to 3 bits.
  - elem_vX = (issue_vX + reg_off) mod 32, 5-bit wrap; no group-legality check.
  - elem_last = (idx == csr_vl-1).
- Widths:
  - idx is 6 bits; max vl = 64 (SEW8, LMUL8), so idx never exceeds 63.
  - vl is compared as 7-bit.
- All elem_* outputs are registered.

Decomposition:
- Shared package:
  - vtype field positions (VALID=6, SEW=5:3, LMUL=2:0).
  - SEW/LMUL encodings 000..011.
  - VLEN.
  - State encoding IDLE/RUN/DONE.
- One natural sub-module, vec_elem_addr: combinational idx/SEW/base-reg to reg number and byte offset; instantiated three times, for vd, vs1 and vs2.

Test Plan:
- Reset, then CSR write vl=8, vtype=7'b1_000_000 -> csr_vl=8, csr_vtype=0x40 next cycle; issue vd=2 with ready held 1 -> 8 beats idx 0..7, elem_vd=2, byte_off 0..7, elem_last on idx 7, seq_done one cycle later.
- vtype SEW=010, LMUL=010, vl=8, vd=4 -> beats with vd 4,4,5,5,6,6,7,7 and byte_off alternating 0,4; stall_id high throughout.
- vtype valid=0 or vl=0, issue -> no elem_valid; seq_done in cycle T+1; issue_ready returns next cycle.
- Backpressure: elem_ready low for 3 cycles at idx 2 -> idx and all elem_* hold; resume at idx 3 when ready rises.
- vcsr_wen and issue_valid in the same IDLE cycle -> issue_ready=0; next cycle the issue is accepted and uses the new vl.
- vd=30, SEW=000, LMUL=011, vl=24 -> registers 30, 31, 0 (wrap); rst asserted mid-RUN -> next cycle all outputs 0, no seq_done.

Source files
------------

// File: rtl/vec_elem_sequencer_pkg.sv
// Shared vtype field layout, SEW/LMUL encodings and sequencer state encoding
// for the vector element sequencer.
package vec_elem_sequencer_pkg;

    localparam int unsigned VLEN_BITS  = 64;

    localparam int unsigned VT_VALID   = 6;
    localparam int unsigned VT_SEW_HI  = 5;
    localparam int unsigned VT_SEW_LO  = 3;
    localparam int unsigned VT_LMUL_HI = 2;
    localparam int unsigned VT_LMUL_LO = 0;

    typedef enum logic [2:0] {
        SEW_8  = 3'b000,
        SEW_16 = 3'b001,
        SEW_32 = 3'b010,
        SEW_64 = 3'b011
    } sew_e;

    typedef enum logic [2:0] {
        LMUL_1 = 3'b000,
        LMUL_2 = 3'b001,
        LMUL_4 = 3'b010,
        LMUL_8 = 3'b011
    } lmul_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/vec_elem_sequencer_addr.sv
// Maps an element index and SEW to the register within the group
// (base + offset, 5-bit wrap) and the byte offset inside that register.
module vec_elem_addr
    import vec_elem_sequencer_pkg::*;
(
    input  logic [5:0] i_idx,
    input  logic [2:0] i_sew,
    input  logic [4:0] i_base,
    output logic [4:0] o_vreg,
    output logic [2:0] o_byte_off
);

    logic [5:0] w_reg_off;

    always_comb begin
        w_reg_off  = '0;
        o_byte_off = '0;
        case (sew_e'(i_sew))
            SEW_8: begin
                w_reg_off  = {3'b000, i_idx[5:3]};
                o_byte_off = i_idx[2:0];
            end
            SEW_16: begin
                w_reg_off  = {2'b00, i_idx[5:2]};
                o_byte_off = {i_idx[1:0], 1'b0};
            end
            SEW_32: begin
                w_reg_off  = {1'b0, i_idx[5:1]};
                o_byte_off = {i_idx[0], 2'b00};
            end
            default: begin
                w_reg_off  = i_idx;
                o_byte_off = '0;
            end
        endcase
    end

    // Register numbers wrap modulo 32; group legality is the caller's problem.
    assign o_vreg = 5'(i_base + w_reg_off);

endmodule

// File: rtl/vec_elem_sequencer.sv
// Latches vl/vtype/AVL CSRs and steps element indices 0..vl-1 of each issued
// vector instruction toward EX over a valid/ready handshake, stalling ID.
module vec_elem_sequencer
    import vec_elem_sequencer_pkg::*;
#(
    parameter int unsigned VLEN = VLEN_BITS,
    parameter int unsigned OPW  = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vcsr_wen,
    input  logic [6:0]     new_vl,
    input  logic [6:0]     new_vtype,
    input  logic [6:0]     new_AVL,
    input  logic           issue_valid,
    output logic           issue_ready,
    input  logic [OPW-1:0] issue_op,
    input  logic [4:0]     issue_vd,
    input  logic [4:0]     issue_vs1,
    input  logic [4:0]     issue_vs2,
    output logic           elem_valid,
    input  logic           elem_ready,
    output logic [OPW-1:0] elem_op,
    output logic [5:0]     elem_idx,
    output logic [4:0]     elem_vd,
    output logic [4:0]     elem_vs1,
    output logic [4:0]     elem_vs2,
    output logic [2:0]     elem_byte_off,
    output logic [2:0]     elem_sew,
    output logic           elem_last,
    output logic           seq_done,
    output logic           stall_id,
    output logic [6:0]     csr_vl,
    output logic [6:0]     csr_vtype,
    output logic [6:0]     csr_avl
);

    localparam int unsigned IDXW = $clog2(VLEN);

    state_e           r_state;
    state_e           w_state_nxt;

    logic [6:0]       r_csr_vl;
    logic [6:0]       r_csr_vtype;
    logic [6:0]       r_csr_avl;

    logic [OPW-1:0]   r_op;
    logic [2:0]       r_sew;
    logic [4:0]       r_vd_base;
    logic [4:0]       r_vs1_base;
    logic [4:0]       r_vs2_base;
    logic [IDXW-1:0]  r_idx;
    logic [4:0]       r_vd;
    logic [4:0]       r_vs1;
    logic [4:0]       r_vs2;
    logic [2:0]       r_byte_off;
    logic             r_last;

    logic             w_idle;
    logic             w_csr_wr;
    logic             w_accept;
    logic             w_beat;
    logic             w_step;
    logic [IDXW-1:0]  w_idx_nxt;
    logic [2:0]       w_sew_sel;
    logic [4:0]       w_vd_base_sel;
    logic [4:0]       w_vs1_base_sel;
    logic [4:0]       w_vs2_base_sel;
    logic [4:0]       w_vd_nxt;
    logic [4:0]       w_vs1_nxt;
    logic [4:0]       w_vs2_nxt;
    logic [2:0]       w_vd_byte_off;
    logic [2:0]       w_vs1_byte_off;
    logic [2:0]       w_vs2_byte_off;
    logic             w_last_nxt;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_csr_wr = w_idle && vcsr_wen;
    assign w_beat   = (r_state == ST_RUN) && elem_ready;
    assign w_step   = w_beat && !r_last;

    // Element fields are registered for the *next* beat: index 0 from the
    // issue inputs on accept, otherwise idx+1 from the latched instruction.
    assign w_idx_nxt      = w_idle ? '0 : r_idx + IDXW'(1);
    assign w_sew_sel      = w_idle ? r_csr_vtype[VT_SEW_HI:VT_SEW_LO] : r_sew;
    assign w_vd_base_sel  = w_idle ? issue_vd  : r_vd_base;
    assign w_vs1_base_sel = w_idle ? issue_vs1 : r_vs1_base;
    assign w_vs2_base_sel = w_idle ? issue_vs2 : r_vs2_base;
    assign w_last_nxt     = ({1'b0, w_idx_nxt} == (r_csr_vl - 7'd1));

    vec_elem_addr u_addr_vd (
        .i_idx      (w_idx_nxt),
        .i_sew      (w_sew_sel),
        .i_base     (w_vd_base_sel),
        .o_vreg     (w_vd_nxt),
        .o_byte_off (w_vd_byte_off)
    );

    vec_elem_addr u_addr_vs1 (
        .i_idx      (w_idx_nxt),
        .i_sew      (w_sew_sel),
        .i_base     (w_vs1_base_sel),
        .o_vreg     (w_vs1_nxt),
        .o_byte_off (w_vs1_byte_off)
    );

    vec_elem_addr u_addr_vs2 (
        .i_idx      (w_idx_nxt),
        .i_sew      (w_sew_sel),
        .i_base     (w_vs2_base_sel),
        .o_vreg     (w_vs2_nxt),
        .o_byte_off (w_vs2_byte_off)
    );

    always_comb begin
        w_state_nxt = r_state;
        issue_ready = 1'b0;
        elem_valid  = 1'b0;
        seq_done    = 1'b0;
        stall_id    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                issue_ready = !vcsr_wen && !rst;
                w_accept    = issue_valid && issue_ready;
                if (w_accept) begin
                    if (!r_csr_vtype[VT_VALID] || (r_csr_vl == '0)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                elem_valid = 1'b1;
                stall_id   = 1'b1;
                if (w_beat && r_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                seq_done    = 1'b1;
                stall_id    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_csr_vl    <= '0;
            r_csr_vtype <= '0;
            r_csr_avl   <= '0;
            r_op        <= '0;
            r_sew       <= '0;
            r_vd_base   <= '0;
            r_vs1_base  <= '0;
            r_vs2_base  <= '0;
            r_idx       <= '0;
            r_vd        <= '0;
            r_vs1       <= '0;
            r_vs2       <= '0;
            r_byte_off  <= '0;
            r_last      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_csr_wr) begin
                r_csr_vl    <= new_vl;
                r_csr_vtype <= new_vtype;
                r_csr_avl   <= new_AVL;
            end
            if (w_accept) begin
                r_op       <= issue_op;
                r_sew      <= w_sew_sel;
                r_vd_base  <= issue_vd;
                r_vs1_base <= issue_vs1;
                r_vs2_base <= issue_vs2;
            end
            if (w_accept || w_step) begin
                r_idx      <= w_idx_nxt;
                r_vd       <= w_vd_nxt;
                r_vs1      <= w_vs1_nxt;
                r_vs2      <= w_vs2_nxt;
                r_byte_off <= w_vd_byte_off;
                r_last     <= w_last_nxt;
            end
        end
    end

    assign elem_op       = r_op;
    assign elem_idx      = r_idx;
    assign elem_vd       = r_vd;
    assign elem_vs1      = r_vs1;
    assign elem_vs2      = r_vs2;
    assign elem_byte_off = r_byte_off;
    assign elem_sew      = r_sew;
    assign elem_last     = r_last;
    assign csr_vl        = r_csr_vl;
    assign csr_vtype     = r_csr_vtype;
    assign csr_avl       = r_csr_avl;

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Directed bench for vec_elem_sequencer: CSR load, beat mapping, backpressure,
// CSR/issue priority, register wrap and mid-run reset.
module tb_vec_elem_sequencer;

    logic       clk;
    logic       rst;
    logic       vcsr_wen;
    logic [6:0] new_vl;
    logic [6:0] new_vtype;
    logic [6:0] new_AVL;
    logic       issue_valid;
    logic       issue_ready;
    logic [5:0] issue_op;
    logic [4:0] issue_vd;
    logic [4:0] issue_vs1;
    logic [4:0] issue_vs2;
    logic       elem_valid;
    logic       elem_ready;
    logic [5:0] elem_op;
    logic [5:0] elem_idx;
    logic [4:0] elem_vd;
    logic [4:0] elem_vs1;
    logic [4:0] elem_vs2;
    logic [2:0] elem_byte_off;
    logic [2:0] elem_sew;
    logic       elem_last;
    logic       seq_done;
    logic       stall_id;
    logic [6:0] csr_vl;
    logic [6:0] csr_vtype;
    logic [6:0] csr_avl;

    int n_cmp = 0;
    int n_err = 0;

    int exp_vd2[8] = '{4, 4, 5, 5, 6, 6, 7, 7};
    int exp_bo2[8] = '{0, 4, 0, 4, 0, 4, 0, 4};

    vec_elem_sequencer #(.VLEN(64), .OPW(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .vcsr_wen      (vcsr_wen),
        .new_vl        (new_vl),
        .new_vtype     (new_vtype),
        .new_AVL       (new_AVL),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_op      (issue_op),
        .issue_vd      (issue_vd),
        .issue_vs1     (issue_vs1),
        .issue_vs2     (issue_vs2),
        .elem_valid    (elem_valid),
        .elem_ready    (elem_ready),
        .elem_op       (elem_op),
        .elem_idx      (elem_idx),
        .elem_vd       (elem_vd),
        .elem_vs1      (elem_vs1),
        .elem_vs2      (elem_vs2),
        .elem_byte_off (elem_byte_off),
        .elem_sew      (elem_sew),
        .elem_last     (elem_last),
        .seq_done      (seq_done),
        .stall_id      (stall_id),
        .csr_vl        (csr_vl),
        .csr_vtype     (csr_vtype),
        .csr_avl       (csr_avl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // CSR writes are only legal while ID is not stalled.
    task automatic csr_write(input logic [6:0] vl, input logic [6:0] vt, input logic [6:0] avl);
        chk("csr_wr_protocol_stall", 32'(stall_id), 32'd0);
        vcsr_wen  = 1'b1;
        new_vl    = vl;
        new_vtype = vt;
        new_AVL   = avl;
        #1;
        chk("csr_wr_issue_ready", 32'(issue_ready), 32'd0);
        cyc();
        vcsr_wen = 1'b0;
        chk("csr_vl", 32'(csr_vl), 32'(vl));
        chk("csr_vtype", 32'(csr_vtype), 32'(vt));
        chk("csr_avl", 32'(csr_avl), 32'(avl));
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_vd    = vd;
        issue_vs1   = vs1;
        issue_vs2   = vs2;
        #1;
        chk("issue_ready", 32'(issue_ready), 32'd1);
        cyc();
        issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vcsr_wen = 1'b0; new_vl = '0; new_vtype = '0; new_AVL = '0;
        issue_valid = 1'b0; issue_op = '0; issue_vd = '0; issue_vs1 = '0; issue_vs2 = '0;
        elem_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_csr_vl", 32'(csr_vl), 32'd0);
        chk("rst_csr_vtype", 32'(csr_vtype), 32'd0);
        chk("rst_elem_valid", 32'(elem_valid), 32'd0);
        chk("rst_seq_done", 32'(seq_done), 32'd0);
        chk("rst_stall_id", 32'(stall_id), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);

        // SEW8 LMUL1 vl=8: one register, byte offsets 0..7
        csr_write(7'd8, 7'h40, 7'd8);
        issue(6'h15, 5'd2, 5'd10, 5'd20);
        chk("t1_op", 32'(elem_op), 32'h15);
        chk("t1_sew", 32'(elem_sew), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", 32'(elem_valid), 32'd1);
            chk("t1_idx", 32'(elem_idx), 32'(i));
            chk("t1_vd", 32'(elem_vd), 32'd2);
            chk("t1_vs1", 32'(elem_vs1), 32'd10);
            chk("t1_boff", 32'(elem_byte_off), 32'(i));
            chk("t1_last", 32'(elem_last), 32'(i == 7));
            chk("t1_done_early", 32'(seq_done), 32'd0);
            cyc();
        end
        chk("t1_done", 32'(seq_done), 32'd1);
        chk("t1_valid_off", 32'(elem_valid), 32'd0);
        chk("t1_stall_done", 32'(stall_id), 32'd1);
        chk("t1_ready_done", 32'(issue_ready), 32'd0);
        cyc();
        chk("t1_done_pulse", 32'(seq_done), 32'd0);
        chk("t1_stall_clr", 32'(stall_id), 32'd0);
        chk("t1_ready_back", 32'(issue_ready), 32'd1);

        // SEW32 LMUL4 vl=8: two elements per register
        csr_write(7'd8, 7'h52, 7'd8);
        issue(6'h2a, 5'd4, 5'd8, 5'd12);
        chk("t2_sew", 32'(elem_sew), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t2_idx", 32'(elem_idx), 32'(i));
            chk("t2_vd", 32'(elem_vd), 32'(exp_vd2[i]));
            chk("t2_boff", 32'(elem_byte_off), 32'(exp_bo2[i]));
            chk("t2_stall", 32'(stall_id), 32'd1);
            chk("t2_last", 32'(elem_last), 32'(i == 7));
            cyc();
        end
        chk("t2_done", 32'(seq_done), 32'd1);
        cyc();

        // vtype invalid: no beats, done right after accept
        csr_write(7'd8, 7'h00, 7'd8);
        issue(6'h01, 5'd1, 5'd1, 5'd1);
        chk("t3a_valid", 32'(elem_valid), 32'd0);
        chk("t3a_done", 32'(seq_done), 32'd1);
        chk("t3a_stall", 32'(stall_id), 32'd1);
        cyc();
        chk("t3a_done_clr", 32'(seq_done), 32'd0);
        chk("t3a_ready", 32'(issue_ready), 32'd1);

        // vl=0 with valid vtype
        csr_write(7'd0, 7'h40, 7'd0);
        issue(6'h01, 5'd1, 5'd1, 5'd1);
        chk("t3b_valid", 32'(elem_valid), 32'd0);
        chk("t3b_done", 32'(seq_done), 32'd1);
        cyc();
        chk("t3b_ready", 32'(issue_ready), 32'd1);

        // Backpressure at idx 2 for three cycles
        csr_write(7'd6, 7'h40, 7'd6);
        issue(6'h07, 5'd1, 5'd3, 5'd5);
        cyc();
        cyc();
        chk("t4_idx2", 32'(elem_idx), 32'd2);
        elem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t4_hold_valid", 32'(elem_valid), 32'd1);
            chk("t4_hold_idx", 32'(elem_idx), 32'd2);
            chk("t4_hold_vd", 32'(elem_vd), 32'd1);
            chk("t4_hold_boff", 32'(elem_byte_off), 32'd2);
            chk("t4_hold_last", 32'(elem_last), 32'd0);
            chk("t4_hold_op", 32'(elem_op), 32'h07);
        end
        elem_ready = 1'b1;
        cyc();
        chk("t4_resume_idx", 32'(elem_idx), 32'd3);
        chk("t4_resume_boff", 32'(elem_byte_off), 32'd3);
        cyc();
        cyc();
        chk("t4_last_idx", 32'(elem_idx), 32'd5);
        chk("t4_last", 32'(elem_last), 32'd1);
        cyc();
        chk("t4_done", 32'(seq_done), 32'd1);
        cyc();

        // CSR write and issue in the same IDLE cycle
        chk("t5_protocol_stall", 32'(stall_id), 32'd0);
        vcsr_wen = 1'b1; new_vl = 7'd3; new_vtype = 7'h40; new_AVL = 7'd3;
        issue_valid = 1'b1; issue_op = 6'h33; issue_vd = 5'd8; issue_vs1 = 5'd9; issue_vs2 = 5'd10;
        #1;
        chk("t5_ready_blocked", 32'(issue_ready), 32'd0);
        cyc();
        vcsr_wen = 1'b0;
        #1;
        chk("t5_csr_vl", 32'(csr_vl), 32'd3);
        chk("t5_ready", 32'(issue_ready), 32'd1);
        cyc();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_valid", 32'(elem_valid), 32'd1);
            chk("t5_idx", 32'(elem_idx), 32'(i));
            chk("t5_last", 32'(elem_last), 32'(i == 2));
            cyc();
        end
        chk("t5_done", 32'(seq_done), 32'd1);
        cyc();

        // SEW8 LMUL8 vl=24 from vd=30: wraps to v0, then reset mid-run
        csr_write(7'd24, 7'h43, 7'd24);
        issue(6'h3f, 5'd30, 5'd5, 5'd31);
        for (int i = 0; i < 18; i++) begin
            chk("t6_idx", 32'(elem_idx), 32'(i));
            chk("t6_vd", 32'(elem_vd), (i < 8) ? 32'd30 : ((i < 16) ? 32'd31 : 32'd0));
            chk("t6_vs2", 32'(elem_vs2), (i < 8) ? 32'd31 : ((i < 16) ? 32'd0 : 32'd1));
            chk("t6_boff", 32'(elem_byte_off), 32'(i & 7));
            chk("t6_last", 32'(elem_last), 32'd0);
            cyc();
        end
        chk("t6_running", 32'(elem_valid), 32'd1);
        rst = 1'b1;
        cyc();
        chk("t6_rst_valid", 32'(elem_valid), 32'd0);
        chk("t6_rst_idx", 32'(elem_idx), 32'd0);
        chk("t6_rst_vd", 32'(elem_vd), 32'd0);
        chk("t6_rst_vs1", 32'(elem_vs1), 32'd0);
        chk("t6_rst_vs2", 32'(elem_vs2), 32'd0);
        chk("t6_rst_boff", 32'(elem_byte_off), 32'd0);
        chk("t6_rst_sew", 32'(elem_sew), 32'd0);
        chk("t6_rst_last", 32'(elem_last), 32'd0);
        chk("t6_rst_op", 32'(elem_op), 32'd0);
        chk("t6_rst_done", 32'(seq_done), 32'd0);
        chk("t6_rst_stall", 32'(stall_id), 32'd0);
        chk("t6_rst_csr_vl", 32'(csr_vl), 32'd0);
        chk("t6_rst_csr_vtype", 32'(csr_vtype), 32'd0);
        chk("t6_rst_csr_avl", 32'(csr_avl), 32'd0);
        rst = 1'b0;
        cyc();
        chk("t6_post_done", 32'(seq_done), 32'd0);
        chk("t6_post_ready", 32'(issue_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
